mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single line-wide main-memory port between the instruction cache (read-only refills) and the data cache (refills and dirty-line writebacks). It sits between both caches and the memory model. It serialises their transactions, latches the winning request onto the memory bus, and steers the one-cycle memory completion pulse back to the owner. Arbitration is round-robin so a miss-heavy data stream cannot starve instruction fetch.

## Interface
Parameters:
- CACHE_LINE_SIZE, 128, width of a memory line transfer in bits
- ADDR_WIDTH, 32, byte-address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_i_read_en  in  1  I-cache line read request, level, held until out_i_ready
- in_i_addr  in  ADDR_WIDTH  I-cache line address
- out_i_read_data  out  CACHE_LINE_SIZE  line data to I-cache, valid with out_i_ready
- out_i_ready  out  1  I-cache transaction complete, one-cycle pulse
- in_d_read_en  in  1  D-cache line read request, level
- in_d_write_en  in  1  D-cache line write (writeback) request, level
- in_d_addr  in  ADDR_WIDTH  D-cache line address
- in_d_write_data  in  CACHE_LINE_SIZE  D-cache writeback line
- out_d_read_data  out  CACHE_LINE_SIZE  line data to D-cache, valid with out_d_ready
- out_d_ready  out  1  D-cache transaction complete, one-cycle pulse
- out_mem_read_en  out  1  memory read request
- out_mem_write_en  out  1  memory write request
- out_mem_addr  out  ADDR_WIDTH  memory address
- out_mem_write_data  out  CACHE_LINE_SIZE  memory write line
- in_mem_read_data  in  CACHE_LINE_SIZE  memory read line, valid with in_mem_ready
- in_mem_ready  in  1  memory completion, one-cycle pulse
- out_busy  out  1  a transaction is outstanding (state != IDLE)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DRAIN.
- Arbitration happens only in IDLE.
  - Only I requesting: grant I.
  - Only D requesting: grant D.
  - Both requesting: grant the requester not in register last_grant.
- A D request is in_d_read_en | in_d_write_en. If both are high, the write is issued and the read is ignored for this grant. The D-cache re-requests the read afterwards.
- On grant, these are registered and held constant for the whole transaction:
  - out_mem_addr and out_mem_write_data (D write only; otherwise 0).
  - out_mem_read_en / out_mem_write_en.
  - last_grant.
- FSM moves to BUSY_I or BUSY_D on grant.
- In BUSY_x, the arbiter waits for in_mem_ready. Requester inputs are not resampled: a requester dropping its request mid-transaction does not abort it.
- On in_mem_ready in BUSY_x:
  - out_x_ready = 1 combinationally in the same cycle.
  - out_mem_read_en/write_en clear at the next edge.
  - FSM moves to DRAIN.
- out_i_read_data and out_d_read_data are driven from in_mem_read_data. They are meaningful only while the matching ready is high.
- out_i_ready = in_mem_ready & (state==BUSY_I). out_d_ready = in_mem_ready & (state==BUSY_D). in_mem_ready in IDLE or DRAIN is ignored.
- DRAIN lasts exactly one cycle and performs no arbitration, then moves to IDLE. This absorbs the requester's still-high request level in the cycle after ready, since requesters deassert one edge after ready.

## Timing
- Reset (async, any state) values:
  - state = IDLE, last_grant = I (D wins first tie).
  - out_mem_read_en = out_mem_write_en = 0, out_mem_addr = 0, out_mem_write_data = 0.
  - out_i_ready = out_d_ready = 0, out_busy = 0.
- Reset mid-transaction abandons it; no ready pulse is generated.
- Request high in IDLE at edge N: memory request asserted after edge N, at cycle N+1.
- in_mem_ready at cycle M: out_x_ready in cycle M. State is DRAIN at M+1 and IDLE at M+2. The earliest next memory request is after edge M+2.
- Back-to-back turnaround: 2 idle cycles between completion and the next request.
- Minimum transaction (memory ready in the first request cycle): 1 request cycle.
- out_busy is registered from state: high from the grant edge through DRAIN inclusive.

## Test plan
- I read alone: in_i_read_en=1, addr 0x0000_0040; memory returns 0xAAAA…AAAA after 3 cycles -> out_mem_read_en=1 with addr 0x40 one cycle after request, held until ready; out_i_ready pulses once with data 0xAAAA…AAAA; out_d_ready stays 0.
- Simultaneous after reset: I read 0x100 and D read 0x200 in the same cycle -> D granted first (addr 0x200), then I (addr 0x100) with exactly 2 idle cycles between; each ready goes only to its owner.
- Round-robin fairness: D holds requests continuously, I requests throughout -> grants alternate D, I, D, I over 4 transactions; no requester granted twice in a row while the other waits.
- D writeback: in_d_write_en=1, addr 0x300, data 0x1234…5678 -> out_mem_write_en=1, out_mem_read_en=0, out_mem_write_data=0x1234…5678; with read_en also high, the write is still issued first.
- Spurious and dropped signals: in_mem_ready pulsed in IDLE -> no ready out, state unchanged; I request dropped mid-BUSY_I -> transaction still completes and out_i_ready still pulses.
- Reset mid-transaction: assert reset in BUSY_D -> all memory outputs and out_busy go 0 immediately; no out_d_ready; after release, a fresh I request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, memory model and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// caches/memory view that drives the requests and the memory completion.
interface mem_arbiter_if #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int ADDR_WIDTH      = 32
) ();
  logic                       in_i_read_en;
  logic [ADDR_WIDTH-1:0]      in_i_addr;
  logic [CACHE_LINE_SIZE-1:0] out_i_read_data;
  logic                       out_i_ready;

  logic                       in_d_read_en;
  logic                       in_d_write_en;
  logic [ADDR_WIDTH-1:0]      in_d_addr;
  logic [CACHE_LINE_SIZE-1:0] in_d_write_data;
  logic [CACHE_LINE_SIZE-1:0] out_d_read_data;
  logic                       out_d_ready;

  logic                       out_mem_read_en;
  logic                       out_mem_write_en;
  logic [ADDR_WIDTH-1:0]      out_mem_addr;
  logic [CACHE_LINE_SIZE-1:0] out_mem_write_data;
  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data;
  logic                       in_mem_ready;

  logic                       out_busy;

  modport slave (
    input  in_i_read_en, in_i_addr,
    output out_i_read_data, out_i_ready,
    input  in_d_read_en, in_d_write_en, in_d_addr, in_d_write_data,
    output out_d_read_data, out_d_ready,
    output out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
    input  in_mem_read_data, in_mem_ready,
    output out_busy
  );

  modport master (
    output in_i_read_en, in_i_addr,
    input  out_i_read_data, out_i_ready,
    output in_d_read_en, in_d_write_en, in_d_addr, in_d_write_data,
    input  out_d_read_data, out_d_ready,
    input  out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
    output in_mem_read_data, in_mem_ready,
    input  out_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the
// I-cache (refills) and the D-cache (refills and writebacks).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction; arbitrate between pending requests
// BUSY_I | I-cache read on the memory bus, waiting for in_mem_ready
// BUSY_D | D-cache read/write on the memory bus, waiting for in_mem_ready
// DRAIN  | one cycle after completion; ignores the owner's stale request
module mem_arbiter #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int ADDR_WIDTH      = 32
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

  state_t                     state_q, state_d;
  grant_t                     last_grant_q, last_grant_d;
  logic                       mem_read_en_q, mem_read_en_d;
  logic                       mem_write_en_q, mem_write_en_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [CACHE_LINE_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                       busy_q, busy_d;

  logic i_req, d_req, grant_i, grant_d;

  // Next-state: arbitrate in IDLE, latch the winner's request, wait for completion.
  always_comb begin
    i_req   = bus.in_i_read_en;
    d_req   = bus.in_d_read_en | bus.in_d_write_en;
    // On a tie the requester that did not win last time goes first.
    grant_d = d_req && (!i_req || (last_grant_q == GRANT_I));
    grant_i = i_req && !grant_d;

    state_d        = state_q;
    last_grant_d   = last_grant_q;
    mem_read_en_d  = mem_read_en_q;
    mem_write_en_d = mem_write_en_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    busy_d         = busy_q;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d        = BUSY_D;
          last_grant_d   = GRANT_D;
          busy_d         = 1'b1;
          mem_addr_d     = bus.in_d_addr;
          // A writeback takes precedence; the D-cache re-requests the read later.
          mem_write_en_d = bus.in_d_write_en;
          mem_read_en_d  = !bus.in_d_write_en;
          mem_wdata_d    = bus.in_d_write_en ? bus.in_d_write_data : '0;
        end else if (grant_i) begin
          state_d        = BUSY_I;
          last_grant_d   = GRANT_I;
          busy_d         = 1'b1;
          mem_addr_d     = bus.in_i_addr;
          mem_read_en_d  = 1'b1;
          mem_write_en_d = 1'b0;
          mem_wdata_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.in_mem_ready) begin
          state_d        = DRAIN;
          mem_read_en_d  = 1'b0;
          mem_write_en_d = 1'b0;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs; reset abandons any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_I;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.out_mem_read_en    = mem_read_en_q;
  assign bus.out_mem_write_en   = mem_write_en_q;
  assign bus.out_mem_addr       = mem_addr_q;
  assign bus.out_mem_write_data = mem_wdata_q;
  assign bus.out_busy           = busy_q;

  // Completion is steered combinationally so the owner sees it in the same cycle.
  assign bus.out_i_ready     = bus.in_mem_ready && (state_q == BUSY_I);
  assign bus.out_d_ready     = bus.in_mem_ready && (state_q == BUSY_D);
  assign bus.out_i_read_data = bus.in_mem_read_data;
  assign bus.out_d_read_data = bus.in_mem_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory transactions are queued
// as requests are driven and checked when the arbiter issues/completes them.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;

  logic clk;
  logic reset;

  mem_arbiter_if #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          owner;   // 0 = I-cache, 1 = D-cache
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push(input logic owner, input logic [AW-1:0] addr, input logic wr,
                      input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    txn_t t;
    t.owner = owner; t.addr = addr; t.wr = wr; t.wdata = wdata; t.rdata = rdata;
    sb.push_back(t);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_i_read_en = 1'b0;  bus.in_i_addr = '0;
    bus.in_d_read_en = 1'b0;  bus.in_d_write_en = 1'b0;
    bus.in_d_addr = '0;       bus.in_d_write_data = '0;
    bus.in_mem_ready = 1'b0;  bus.in_mem_read_data = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Counts negedges until a memory request is visible; bounded.
  task automatic wait_req(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(bus.out_mem_read_en | bus.out_mem_write_en) && cnt < 40);
    chk("req_seen", bus.out_mem_read_en | bus.out_mem_write_en, 1'b1);
    if (!(bus.out_mem_read_en | bus.out_mem_write_en)) cnt = -1;
  endtask

  // Called at a negedge with a request visible; memory answers after lat cycles.
  task automatic serve(input int lat, input bit drop);
    txn_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 1'b0, 1'b1);
      return;
    end
    e = sb.pop_front();
    chk("mem_addr",  bus.out_mem_addr, e.addr);
    chk("mem_wr",    bus.out_mem_write_en, e.wr);
    chk("mem_rd",    bus.out_mem_read_en, !e.wr);
    chk("mem_wdata", bus.out_mem_write_data, e.wr ? e.wdata : '0);
    chk("busy",      bus.out_busy, 1'b1);
    if (lat == 0) begin
      bus.in_mem_ready = 1'b1;
      bus.in_mem_read_data = e.rdata;
      #1;
    end else begin
      for (int k = 0; k < lat; k++) begin
        @(posedge clk); #1;
        if (k == lat - 1) begin
          bus.in_mem_ready = 1'b1;
          bus.in_mem_read_data = e.rdata;
        end
        @(negedge clk);
        if (k < lat - 1) begin
          chk("hold_addr", bus.out_mem_addr, e.addr);
          chk("hold_en", bus.out_mem_read_en | bus.out_mem_write_en, 1'b1);
        end
      end
    end
    chk("i_ready", bus.out_i_ready, e.owner == 1'b0);
    chk("d_ready", bus.out_d_ready, e.owner == 1'b1);
    chk("rdata", e.owner ? bus.out_d_read_data : bus.out_i_read_data, e.rdata);
    @(posedge clk); #1;
    bus.in_mem_ready = 1'b0;
    bus.in_mem_read_data = rnd_line();
    if (drop) begin
      if (e.owner == 1'b0) bus.in_i_read_en = 1'b0;
      else begin
        bus.in_d_read_en = 1'b0;
        bus.in_d_write_en = 1'b0;
      end
    end
    @(negedge clk);
    chk("drain_busy", bus.out_busy, 1'b1);
    chk("drain_en", bus.out_mem_read_en | bus.out_mem_write_en, 1'b0);
    chk("drain_rdy", bus.out_i_ready | bus.out_d_ready, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [LW-1:0] aaaa;
    logic [LW-1:0] wb;
    n_cmp = 0;
    n_err = 0;
    aaaa = {32{4'hA}};
    wb   = {4{32'h12345678}};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_busy",  bus.out_busy, 1'b0);
    chk("rst_rd",    bus.out_mem_read_en, 1'b0);
    chk("rst_wr",    bus.out_mem_write_en, 1'b0);
    chk("rst_addr",  bus.out_mem_addr, '0);
    chk("rst_wdata", bus.out_mem_write_data, '0);
    chk("rst_rdy",   bus.out_i_ready | bus.out_d_ready, 1'b0);

    // I read alone, memory answers after 3 cycles
    @(posedge clk); #1;
    bus.in_i_read_en = 1'b1; bus.in_i_addr = 32'h40;
    push(1'b0, 32'h40, 1'b0, '0, aaaa);
    wait_req(cnt);
    chk("i_lat", cnt, 2);
    if (cnt > 0) serve(3, 1'b1);

    // Spurious completion while idle
    @(posedge clk); #1;
    bus.in_mem_ready = 1'b1;
    @(negedge clk);
    chk("spur_rdy", bus.out_i_ready | bus.out_d_ready, 1'b0);
    @(posedge clk); #1;
    bus.in_mem_ready = 1'b0;
    @(negedge clk);
    chk("spur_busy", bus.out_busy, 1'b0);
    chk("spur_en", bus.out_mem_read_en | bus.out_mem_write_en, 1'b0);

    // I request dropped mid-transaction still completes
    @(posedge clk); #1;
    bus.in_i_read_en = 1'b1; bus.in_i_addr = 32'h80;
    push(1'b0, 32'h80, 1'b0, '0, rnd_line());
    wait_req(cnt);
    bus.in_i_read_en = 1'b0;
    if (cnt > 0) serve(2, 1'b1);

    // Simultaneous after reset: D first, then I after 2 idle cycles
    do_reset();
    bus.in_i_read_en = 1'b1; bus.in_i_addr = 32'h100;
    bus.in_d_read_en = 1'b1; bus.in_d_addr = 32'h200;
    push(1'b1, 32'h200, 1'b0, '0, rnd_line());
    push(1'b0, 32'h100, 1'b0, '0, rnd_line());
    wait_req(cnt);
    if (cnt > 0) serve(1, 1'b1);
    wait_req(cnt);
    chk("turnaround", cnt, 2);
    if (cnt > 0) serve(0, 1'b1);

    // Round-robin with both requesting continuously
    do_reset();
    bus.in_d_read_en = 1'b1; bus.in_d_addr = 32'h1000;
    bus.in_i_read_en = 1'b1; bus.in_i_addr = 32'h2000;
    push(1'b1, 32'h1000, 1'b0, '0, rnd_line());
    push(1'b0, 32'h2000, 1'b0, '0, rnd_line());
    push(1'b1, 32'h1040, 1'b0, '0, rnd_line());
    push(1'b0, 32'h2040, 1'b0, '0, rnd_line());
    for (int t = 0; t < 4; t++) begin
      wait_req(cnt);
      if (cnt > 0) serve(2, 1'b0);
      if (t % 2 == 0) bus.in_d_addr = bus.in_d_addr + 32'h40;
      else            bus.in_i_addr = bus.in_i_addr + 32'h40;
    end
    bus.in_d_read_en = 1'b0;
    bus.in_i_read_en = 1'b0;

    // D writeback with read also pending: write first, then the read
    @(posedge clk); #1;
    bus.in_d_write_en = 1'b1; bus.in_d_read_en = 1'b1;
    bus.in_d_addr = 32'h300; bus.in_d_write_data = wb;
    push(1'b1, 32'h300, 1'b1, wb, rnd_line());
    wait_req(cnt);
    if (cnt > 0) serve(2, 1'b0);
    bus.in_d_write_en = 1'b0;
    push(1'b1, 32'h300, 1'b0, '0, rnd_line());
    wait_req(cnt);
    chk("wb_turnaround", cnt, 2);
    if (cnt > 0) serve(1, 1'b1);

    // Reset in BUSY_D abandons the transaction
    @(posedge clk); #1;
    bus.in_d_read_en = 1'b1; bus.in_d_addr = 32'h400;
    wait_req(cnt);
    chk("rm_addr_pre", bus.out_mem_addr, 32'h400);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rm_busy", bus.out_busy, 1'b0);
    chk("rm_en", bus.out_mem_read_en | bus.out_mem_write_en, 1'b0);
    chk("rm_addr", bus.out_mem_addr, '0);
    bus.in_mem_ready = 1'b1;
    #1;
    chk("rm_drdy", bus.out_d_ready, 1'b0);
    bus.in_mem_ready = 1'b0;
    bus.in_d_read_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_i_read_en = 1'b1; bus.in_i_addr = 32'h500;
    push(1'b0, 32'h500, 1'b0, '0, rnd_line());
    wait_req(cnt);
    chk("rm_i_lat", cnt, 2);
    if (cnt > 0) serve(1, 1'b1);

    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
